// File: rtl/instruction_pkg.sv
// Shared RV32I instruction types: decoded-instruction struct, format enum and
// base opcode constants used by the decoder, encoder and trace path.
package instruction;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } format_e;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] SYSTEM = 7'h73;

  typedef struct packed {
    format_e     format;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } t;

  // True when the bits selected by mask are all ones or all zeros, i.e. the
  // immediate is a proper sign extension of the field that gets encoded.
  function automatic logic sign_run_ok(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'h0);
  endfunction

endpackage

// File: rtl/instruction_encoder_comb.sv
// Pure combinational RV32I encoder: decoded instruction to machine word, with
// a flag for immediates that do not fit the chosen format.
module instruction_encoder_comb
  import instruction::*;
(
  input  instruction::t instr_i,
  output logic [31:0]   word_o,
  output logic          error_o
);

  logic [31:0] imm;
  logic        isShift;

  assign imm     = instr_i.imm;
  assign isShift = (instr_i.opcode == OP_IMM) && (instr_i.funct3[1:0] == 2'b01);

  always_comb begin
    word_o  = 32'h0;
    error_o = 1'b0;
    unique case (instr_i.format)
      FMT_R: begin
        word_o = {instr_i.funct7, instr_i.rs2, instr_i.rs1, instr_i.funct3,
                  instr_i.rd, instr_i.opcode};
      end
      FMT_I: begin
        word_o  = {imm[11:0], instr_i.rs1, instr_i.funct3, instr_i.rd, instr_i.opcode};
        // Shift-immediates carry their funct7 (e.g. srai) in the upper imm bits.
        if (isShift) word_o[31:25] = instr_i.funct7;
        error_o = !sign_run_ok(imm, 32'hFFFF_F800);
      end
      FMT_S: begin
        word_o  = {imm[11:5], instr_i.rs2, instr_i.rs1, instr_i.funct3, imm[4:0],
                   instr_i.opcode};
        error_o = !sign_run_ok(imm, 32'hFFFF_F800);
      end
      FMT_B: begin
        word_o  = {imm[12], imm[10:5], instr_i.rs2, instr_i.rs1, instr_i.funct3,
                   imm[4:1], imm[11], instr_i.opcode};
        error_o = !sign_run_ok(imm, 32'hFFFF_F000) || imm[0];
      end
      FMT_U: begin
        word_o  = {imm[31:12], instr_i.rd, instr_i.opcode};
        error_o = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        word_o  = {imm[20], imm[10:1], imm[11], imm[19:12], instr_i.rd, instr_i.opcode};
        error_o = !sign_run_ok(imm, 32'hFFF0_0000) || imm[0];
      end
      default: begin
        word_o  = 32'h0;
        error_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder_stream.sv
// Two-stage elastic RV32I encoder: S1 holds the decoded instruction, S2 holds
// the encoded word and error flag; counts handed-off words and errors.
module instruction_encoder_stream
  import instruction::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  instruction::t    instruction_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      word_out,
  output logic             out_error,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] error_count
);

  logic             s1_valid_q, s1_valid_d;
  instruction::t    s1_instr_q, s1_instr_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_word_q, s2_word_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] error_count_q, error_count_d;

  logic        s2_advance, s1_advance, handoff;
  logic [31:0] enc_word;
  logic        enc_error;

  instruction_encoder_comb u_enc (
    .instr_i (s1_instr_q),
    .word_o  (enc_word),
    .error_o (enc_error)
  );

  assign s2_advance = !s2_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready   = s1_advance && !rst;
  assign handoff    = s2_valid_q && out_ready;

  // Each stage reloads only when the stage downstream frees up, so a stalled
  // output freezes the whole pipe without losing anything.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_instr_d    = s1_instr_q;
    s2_valid_d    = s2_valid_q;
    s2_word_d     = s2_word_q;
    s2_err_d      = s2_err_q;
    word_count_d  = word_count_q;
    error_count_d = error_count_q;
    if (s1_advance) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_instr_d = instruction_in;
    end
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_word_d = enc_word;
        s2_err_d  = enc_error;
      end
    end
    if (handoff) begin
      word_count_d = word_count_q + CNT_W'(1);
      if (s2_err_q) error_count_d = error_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_instr_q    <= '0;
      s2_valid_q    <= 1'b0;
      s2_word_q     <= 32'h0;
      s2_err_q      <= 1'b0;
      word_count_q  <= '0;
      error_count_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_instr_q    <= s1_instr_d;
      s2_valid_q    <= s2_valid_d;
      s2_word_q     <= s2_word_d;
      s2_err_q      <= s2_err_d;
      word_count_q  <= word_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign word_out    = s2_word_q;
  assign out_error   = s2_err_q;
  assign word_count  = word_count_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_instruction_encoder_stream.sv
// Directed bench for instruction_encoder_stream: encode table, latency,
// backpressure, full-rate round trip, async reset and counter wrap.
module tb_instruction_encoder_stream;
  import instruction::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  instruction::t instruction_in = '0;

  logic        in_ready, out_valid, out_error;
  logic [31:0] word_out;
  logic [15:0] word_count, error_count;

  logic        in_ready4, out_valid4, out_error4;
  logic [31:0] word_out4;
  logic [3:0]  word_count4, error_count4;

  instruction_encoder_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .out_valid(out_valid), .out_ready(out_ready),
    .word_out(word_out), .out_error(out_error),
    .word_count(word_count), .error_count(error_count)
  );

  instruction_encoder_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .instruction_in(instruction_in), .out_valid(out_valid4), .out_ready(out_ready),
    .word_out(word_out4), .out_error(out_error4),
    .word_count(word_count4), .error_count(error_count4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acceptCnt = 0;
  logic abortPush = 1'b0;

  logic [31:0] recvWord[$];
  logic        recvErr[$];
  int          recvCyc[$];

  typedef struct {
    string         name;
    instruction::t ins;
    logic [31:0]   w;
    logic          e;
  } vec_t;

  vec_t vecs[13];
  instruction::t sent[100];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transfer that the next rising edge will complete.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      recvWord.push_back(word_out);
      recvErr.push_back(out_error);
      recvCyc.push_back(cyc);
    end
  end

  function automatic instruction::t mk(input format_e f, input logic [6:0] opc,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] imm);
    instruction::t x;
    x.format = f; x.opcode = opc; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
    x.funct3 = f3; x.funct7 = f7; x.imm = imm;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input instruction::t x);
    bit ok = 1'b0;
    in_valid = 1'b1;
    instruction_in = x;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (abortPush) break;
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!abortPush && !ok) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (ok) acceptCnt++;
    in_valid = 1'b0;
  endtask

  task automatic waitRecv(input int n, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (recvWord.size() >= n) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("recv_timeout", recvWord.size(), n);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    recvWord.delete(); recvErr.delete(); recvCyc.delete();
    acceptCnt = 0;
  endtask

  initial begin
    vecs[0]  = '{"add",      mk(FMT_R, OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0),        32'h002081B3, 1'b0};
    vecs[1]  = '{"addi_m1",  mk(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF), 32'hFFF10093, 1'b0};
    vecs[2]  = '{"srai",     mk(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h3),        32'h40315093, 1'b0};
    vecs[3]  = '{"sw",       mk(FMT_S, STORE,  5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h8),        32'h00512423, 1'b0};
    vecs[4]  = '{"lui",      mk(FMT_U, LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000), 32'h123452B7, 1'b0};
    vecs[5]  = '{"beq_m4",   mk(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC), 32'hFE000EE3, 1'b0};
    vecs[6]  = '{"jal_8",    mk(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8),        32'h008000EF, 1'b0};
    vecs[7]  = '{"addi_2048",mk(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h800),      32'h80010093, 1'b1};
    vecs[8]  = '{"addi_m2048",mk(FMT_I, OP_IMM,5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFFF800), 32'h80010093, 1'b0};
    vecs[9]  = '{"beq_odd",  mk(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h7),        32'h00000363, 1'b1};
    vecs[10] = '{"lui_low",  mk(FMT_U, LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001), 32'h123452B7, 1'b1};
    vecs[11] = '{"jal_odd",  mk(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h9),        32'h008000EF, 1'b1};
    vecs[12] = '{"bad_fmt",  mk(format_e'(3'd7), OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0),  32'h00000000, 1'b1};

    // Reset state while rst is held.
    in_valid = 1'b1;
    instruction_in = vecs[0].ins;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_word_out", word_out, 0);
    checkOutput("rst_out_error", out_error, 0);
    checkOutput("rst_word_count", word_count, 0);
    checkOutput("rst_error_count", error_count, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency: accept at cycle N, out_valid in cycle N+2.
    in_valid = 1'b1;
    instruction_in = vecs[1].ins;
    @(negedge clk);
    checkOutput("lat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_n1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("lat_n2_valid", out_valid, 1);
    checkOutput("lat_n2_word", word_out, 32'hFFF10093);
    @(negedge clk);
    checkOutput("lat_n3_valid", out_valid, 0);

    // Table of single-format encodes and range errors, streamed back to back.
    doReset();
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i].ins);
    waitRecv(13, 100);
    for (int i = 0; i < 13; i++) begin
      if (i < recvWord.size()) begin
        checkOutput({vecs[i].name, "_word"}, recvWord[i], vecs[i].w);
        checkOutput({vecs[i].name, "_err"}, {31'd0, recvErr[i]}, {31'd0, vecs[i].e});
      end else begin
        checkOutput({vecs[i].name, "_missing"}, 0, 1);
      end
    end
    checkOutput("tbl_word_count", word_count, 13);
    checkOutput("tbl_error_count", error_count, 5);

    // Backpressure: four instructions against a stalled consumer.
    doReset();
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i].ins);
    join_none
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_word_stable", word_out, vecs[0].w);
    end
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_accepts", acceptCnt, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    waitRecv(4, 100);
    for (int i = 0; i < 4; i++) begin
      if (i < recvWord.size()) checkOutput("bp_order", recvWord[i], vecs[i].w);
      else checkOutput("bp_missing", 0, 1);
    end
    checkOutput("bp_word_count", word_count, 4);

    // Full-rate stream of random addi, decoded back field by field.
    doReset();
    for (int i = 0; i < 100; i++) begin
      sent[i] = mk(FMT_I, OP_IMM, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'd0, 3'd0, 7'd0, 32'($signed($urandom_range(0, 4095)) - 2048));
    end
    for (int i = 0; i < 100; i++) applyStimulus(sent[i]);
    waitRecv(100, 400);
    if (recvWord.size() >= 100) begin
      for (int i = 0; i < 100; i++) begin
        logic [31:0] w;
        logic [63:0] dec, ref_f;
        w = recvWord[i];
        dec   = {w[6:0], w[11:7], w[19:15], w[14:12], {{20{w[31]}}, w[31:20]}, 12'd0};
        ref_f = {sent[i].opcode, sent[i].rd, sent[i].rs1, sent[i].funct3, sent[i].imm, 12'd0};
        checkOutput("rt_fields_hi", dec[63:32], ref_f[63:32]);
        checkOutput("rt_fields_lo", dec[31:0], ref_f[31:0]);
      end
      checkOutput("rt_rate", recvCyc[99] - recvCyc[0], 99);
    end
    checkOutput("rt_word_count", word_count, 100);
    checkOutput("rt_error_count", error_count, 0);

    // Async reset asserted between edges in the middle of a stream.
    doReset();
    fork
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i % 7].ins);
    join_none
    repeat (4) @(posedge clk);
    #3;
    abortPush = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_word_out", word_out, 0);
    checkOutput("arst_word_count", word_count, 0);
    checkOutput("arst_in_ready", in_ready, 0);
    wait fork;
    in_valid = 1'b0;
    abortPush = 1'b0;
    doReset();
    applyStimulus(vecs[3].ins);
    waitRecv(1, 20);
    if (recvWord.size() >= 1) checkOutput("arst_first_word", recvWord[0], vecs[3].w);
    checkOutput("arst_count_after", word_count, 1);

    // Counter wrap on the 4-bit instance.
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(vecs[7].ins);
    waitRecv(17, 100);
    checkOutput("wrap_word_count4", word_count4, 1);
    checkOutput("wrap_error_count4", error_count4, 1);
    checkOutput("wrap_word_count16", word_count, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
